uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, meaning the number of byte requesters (2..8).
REQ-002 The block SHALL have parameter START_TIMEOUT, default 16, meaning the maximum number of cycles to wait for tx_busy to rise after tx_start.
REQ-003 The block SHALL run on one clock with a synchronous, active-high reset; ports clk and reset.
REQ-004 clk  input  1  system clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  NREQ  requester i has a byte pending.
REQ-007 req_data  input  8*NREQ  byte of requester i in bits [8i+7:8i].
REQ-008 req_ready  output  NREQ  one-hot acceptance; a byte transfers on a clock edge where req_valid[i] & req_ready[i].
REQ-009 tx_start  output  1  start strobe to the UART transmitter.
REQ-010 tx_data  output  8  byte to the UART transmitter.
REQ-011 tx_busy  input  1  busy flag from the UART transmitter.
REQ-012 grant_id  output  clog2(NREQ)  index of the last accepted requester.
REQ-013 active  output  1  high whenever the FSM is not in IDLE.
REQ-014 timeout_err  output  1  sticky flag: the transmitter failed to go busy within START_TIMEOUT cycles.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, START and WAIT.
REQ-016 In IDLE with tx_busy=0 and any req_valid set, req_ready SHALL assert combinationally for exactly one requester, chosen round-robin.
REQ-017 Round-robin search SHALL begin at index (last_grant+1) mod NREQ and wrap, so a continuously requesting source waits at most NREQ-1 transfers.
REQ-018 req_ready SHALL be all-zero in START and WAIT, and in IDLE while tx_busy=1.
REQ-019 On a transfer edge: the byte is latched into tx_data, grant_id and last_grant are updated, and the FSM moves IDLE->START.
REQ-020 In START, tx_start SHALL be 1 and a timeout counter SHALL increment each cycle; the counter is cleared on entry to START.
REQ-021 START->WAIT SHALL occur on the first edge with tx_busy=1; tx_start deasserts in that same transition.
REQ-022 If tx_busy has not risen after START_TIMEOUT cycles in START, the FSM SHALL go to IDLE, set timeout_err and discard the byte.
REQ-023 WAIT->IDLE SHALL occur on the first edge with tx_busy=0; the next grant is possible in the following cycle.
REQ-024 tx_data SHALL remain stable from the transfer edge until the FSM returns to IDLE.
REQ-025 Minimum latency SHALL be: transfer edge, then tx_start high in the next cycle.
REQ-026 Deassertion of req_valid while not granted SHALL have no effect; no byte is consumed without req_ready.
REQ-027 timeout_err SHALL clear only on reset.

Reset
REQ-028 reset SHALL force: state IDLE, tx_start=0, tx_data=0x00, grant_id=0, last_grant=NREQ-1 (so index 0 wins first), timeout counter=0, timeout_err=0, active=0.
REQ-029 reset asserted mid-transfer SHALL abandon the byte; no tx_start is issued after reset deasserts unless a new transfer occurs.

Structure
REQ-030 A shared package uart_ctrl_pkg SHALL hold the state enumeration, the default NREQ and the byte-width constant (8).
REQ-031 Round-robin selection SHALL be a sub-module rr_arbiter, with inputs req and last_grant and outputs a one-hot grant and its index.

Verification
REQ-032 Single request: req_valid=0001, req_data[7:0]=0x41, with tx_busy rising one cycle after tx_start and held 10 cycles -> one ready pulse on bit 0, tx_data=0x41, one START cycle, IDLE after tx_busy falls.
REQ-033 All four requesting continuously with data 0xA0..0xA3 -> grant order 0,1,2,3,0, with no requester granted twice before the others.
REQ-034 tx_busy held at 0 -> after 16 START cycles, return to IDLE with timeout_err=1 and req_ready still available.
REQ-035 reset pulsed during WAIT -> next cycle state IDLE, all outputs at reset values, and the next grant goes to index 0.
REQ-036 tx_busy=1 while in IDLE (external transmission) with req_valid=0010 -> req_ready=0 until tx_busy=0, then bit 1 is granted.
REQ-037 Requester 2 drops req_valid in the cycle requester 1 is granted -> requester 2 is never granted and no stray byte appears on tx_data.

Source files
------------

// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   state_e      : arbiter FSM states (IDLE, START, WAIT)
//   DEFAULT_NREQ : default number of byte requesters
//   BYTE_W       : width of one transmitted byte
package uart_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    localparam int DEFAULT_NREQ = 4;
    localparam int BYTE_W       = 8;

endpackage : uart_ctrl_pkg

// File: rtl/rr_arbiter.sv
// Round-robin selector. Purely combinational.
// Ports:
//   req        : in  NREQ            request vector
//   last_grant : in  clog2(NREQ)     index granted most recently
//   grant      : out NREQ            one-hot winner (all-zero when no request)
//   grant_idx  : out clog2(NREQ)     index of the winner (0 when no request)
// The search starts one position after last_grant and wraps, so every
// requester is visited before any requester is visited twice.
module rr_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int NREQ = DEFAULT_NREQ
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] last_grant,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] grant_idx
);

    localparam int IDXW = $clog2(NREQ);

    int             j;
    logic [IDXW-1:0] cand;
    logic           found;

    // Scan NREQ positions starting after last_grant; first hit wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        j         = 0;
        cand      = '0;
        for (int i = 1; i <= NREQ; i++) begin
            j = int'(last_grant) + i;
            if (j >= NREQ) begin
                j = j - NREQ;
            end else begin
                j = j;
            end
            cand = IDXW'(j);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end else begin
                found = found;
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/uart_tx_arbiter.sv
// Arbitrates NREQ byte requesters onto a single UART transmitter.
// Ports:
//   clk, reset  : clock and synchronous active-high reset
//   req_valid   : in  NREQ    requester i has a byte pending
//   req_data    : in  8*NREQ  byte of requester i in bits [8i+7:8i]
//   req_ready   : out NREQ    one-hot acceptance (combinational, IDLE only)
//   tx_start    : out 1       start strobe, high for every START cycle
//   tx_data     : out 8       accepted byte, stable until back in IDLE
//   tx_busy     : in  1       transmitter busy flag
//   grant_id    : out clog2   index of the last accepted requester
//   active      : out 1       FSM not in IDLE
//   timeout_err : out 1       sticky: transmitter never went busy after start
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int NREQ          = DEFAULT_NREQ,
    parameter int START_TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [BYTE_W*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     tx_start,
    output logic [BYTE_W-1:0]        tx_data,
    input  logic                     tx_busy,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     active,
    output logic                     timeout_err
);

    localparam int IDXW = $clog2(NREQ);
    localparam int CNTW = $clog2(START_TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [BYTE_W-1:0] tx_data_q, tx_data_d;
    logic [IDXW-1:0]   grant_id_q, grant_id_d;
    logic [IDXW-1:0]   last_grant_q, last_grant_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              tx_start_q, tx_start_d;
    logic              active_q, active_d;
    logic              timeout_err_q, timeout_err_d;

    logic [NREQ-1:0]   arb_grant;
    logic [IDXW-1:0]   arb_idx;
    logic [IDXW+2:0]   sel_base;
    logic [BYTE_W-1:0] sel_byte;
    logic              transfer;

    rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant      (arb_grant),
        .grant_idx  (arb_idx)
    );

    // Offer the arbiter winner only when idle and the transmitter is free.
    always_comb begin
        sel_base = {arb_idx, 3'b000};
        sel_byte = req_data[sel_base +: BYTE_W];
        if ((state_q == ST_IDLE) && !tx_busy) begin
            req_ready = arb_grant;
        end else begin
            req_ready = '0;
        end
        transfer = |(req_valid & req_ready);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        tx_data_d     = tx_data_q;
        grant_id_d    = grant_id_q;
        last_grant_d  = last_grant_q;
        cnt_d         = cnt_q;
        timeout_err_d = timeout_err_q;
        case (state_q)
            ST_IDLE: begin
                if (transfer) begin
                    state_d      = ST_START;
                    tx_data_d    = sel_byte;
                    grant_id_d   = arb_idx;
                    last_grant_d = arb_idx;
                    cnt_d        = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                cnt_d = cnt_q + CNTW'(1);
                if (tx_busy) begin
                    state_d = ST_WAIT;
                end else if (cnt_q == CNTW'(START_TIMEOUT - 1)) begin
                    // Transmitter never responded: drop the byte and flag it.
                    state_d       = ST_IDLE;
                    timeout_err_d = 1'b1;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_WAIT: begin
                if (!tx_busy) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Strobes are registered copies of the next state decode.
        tx_start_d = (state_d == ST_START);
        active_d   = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            tx_data_q     <= '0;
            grant_id_q    <= '0;
            last_grant_q  <= IDXW'(NREQ - 1);
            cnt_q         <= '0;
            tx_start_q    <= 1'b0;
            active_q      <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tx_data_q     <= tx_data_d;
            grant_id_q    <= grant_id_d;
            last_grant_q  <= last_grant_d;
            cnt_q         <= cnt_d;
            tx_start_q    <= tx_start_d;
            active_q      <= active_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign grant_id    = grant_id_q;
    assign active      = active_q;
    assign timeout_err = timeout_err_q;

endmodule : uart_tx_arbiter

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter (NREQ=4, START_TIMEOUT=16).
module tb_uart_tx_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic [1:0]  grant_id;
    logic        active;
    logic        timeout_err;

    int n_cmp = 0;
    int n_err = 0;

    uart_tx_arbiter #(.NREQ(4), .START_TIMEOUT(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .active      (active),
        .timeout_err (timeout_err)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required normal end");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transmitter goes busy one cycle after start, then releases.
    task automatic finish_handshake(input string tag, input int busy_cycles);
        tx_busy = 1'b1;
        tick();
        check({tag, "_wait_start"}, {31'd0, tx_start}, 32'd0);
        check({tag, "_wait_active"}, {31'd0, active}, 32'd1);
        for (int k = 1; k < busy_cycles; k++) begin
            tick();
        end
        check({tag, "_wait_ready"}, {28'd0, req_ready}, 32'd0);
        tx_busy = 1'b0;
        tick();
        check({tag, "_idle_active"}, {31'd0, active}, 32'd0);
    endtask

    int n_start;
    logic [7:0] exp_byte;

    initial begin
        reset     = 1'b1;
        req_valid = 4'b0000;
        req_data  = 32'h0000_0000;
        tx_busy   = 1'b0;
        tick();
        tick();
        // Reset state
        check("rst_tx_start", {31'd0, tx_start}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_grant_id", {30'd0, grant_id}, 32'd0);
        check("rst_active", {31'd0, active}, 32'd0);
        check("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
        reset = 1'b0;

        // Single request on bit 0
        req_valid = 4'b0001;
        req_data  = 32'h0000_0041;
        #1;
        check("single_ready", {28'd0, req_ready}, 32'h1);
        tick();
        req_valid = 4'b0000;
        #1;
        check("single_ready_pulse", {28'd0, req_ready}, 32'h0);
        check("single_tx_start", {31'd0, tx_start}, 32'd1);
        check("single_tx_data", {24'd0, tx_data}, 32'h41);
        check("single_grant_id", {30'd0, grant_id}, 32'd0);
        finish_handshake("single", 10);
        check("single_tx_data_hold", {24'd0, tx_data}, 32'h41);

        // Round robin with all four requesting; restart from index 0
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req_valid = 4'b1111;
        req_data  = 32'hA3A2_A1A0;
        for (int g = 0; g < 5; g++) begin
            #1;
            check($sformatf("rr%0d_ready", g), {28'd0, req_ready}, 32'd1 << (g % 4));
            tick();
            exp_byte = 8'hA0 + 8'(g % 4);
            check($sformatf("rr%0d_grant_id", g), {30'd0, grant_id}, 32'(g % 4));
            check($sformatf("rr%0d_tx_data", g), {24'd0, tx_data}, {24'd0, exp_byte});
            check($sformatf("rr%0d_tx_start", g), {31'd0, tx_start}, 32'd1);
            finish_handshake($sformatf("rr%0d", g), 1);
        end
        req_valid = 4'b0000;
        // last grant is now 0

        // Timeout: transmitter never goes busy
        req_valid = 4'b0010;
        req_data  = 32'h0000_5500;
        tick();
        req_valid = 4'b0000;
        n_start = 0;
        for (int k = 0; k < 40; k++) begin
            if (tx_start) begin
                n_start++;
                tick();
            end else begin
                break;
            end
        end
        check("to_start_cycles", 32'(n_start), 32'd16);
        check("to_active", {31'd0, active}, 32'd0);
        check("to_err", {31'd0, timeout_err}, 32'd1);
        req_valid = 4'b0100;
        #1;
        check("to_ready_avail", {28'd0, req_ready}, 32'h4);
        req_valid = 4'b0000;
        tick();
        // last grant is still 1

        // External transmission blocks grants
        tx_busy   = 1'b1;
        req_valid = 4'b0010;
        req_data  = 32'h0000_6200;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("ext%0d_ready", k), {28'd0, req_ready}, 32'h0);
            tick();
            check($sformatf("ext%0d_active", k), {31'd0, active}, 32'd0);
        end
        tx_busy = 1'b0;
        #1;
        check("ext_ready", {28'd0, req_ready}, 32'h2);
        tick();
        req_valid = 4'b0000;
        check("ext_grant_id", {30'd0, grant_id}, 32'd1);
        check("ext_tx_data", {24'd0, tx_data}, 32'h62);
        check("ext_err_sticky", {31'd0, timeout_err}, 32'd1);
        finish_handshake("ext", 2);

        // Reset during WAIT
        req_valid = 4'b0100;
        req_data  = 32'h0077_0000;
        tick();
        req_valid = 4'b0000;
        check("mid_grant_id", {30'd0, grant_id}, 32'd2);
        tx_busy = 1'b1;
        tick();
        check("mid_in_wait", {31'd0, active & ~tx_start}, 32'd1);
        reset   = 1'b1;
        tx_busy = 1'b0;
        tick();
        reset = 1'b0;
        check("mid_rst_active", {31'd0, active}, 32'd0);
        check("mid_rst_tx_start", {31'd0, tx_start}, 32'd0);
        check("mid_rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("mid_rst_grant_id", {30'd0, grant_id}, 32'd0);
        check("mid_rst_err", {31'd0, timeout_err}, 32'd0);
        tick();
        tick();
        check("mid_no_stray_start", {31'd0, tx_start}, 32'd0);
        req_valid = 4'b1111;
        req_data  = 32'h1312_1110;
        #1;
        check("mid_next_ready", {28'd0, req_ready}, 32'h1);
        tick();
        req_valid = 4'b0000;
        check("mid_next_data", {24'd0, tx_data}, 32'h10);
        finish_handshake("mid", 1);
        // last grant is now 0

        // Requester 2 withdraws while requester 1 is granted
        req_valid = 4'b0110;
        req_data  = 32'h00C2_C100;
        #1;
        check("drop_ready", {28'd0, req_ready}, 32'h2);
        req_valid = 4'b0010;
        #1;
        check("drop_ready_hold", {28'd0, req_ready}, 32'h2);
        tick();
        req_valid = 4'b0000;
        check("drop_grant_id", {30'd0, grant_id}, 32'd1);
        check("drop_tx_data", {24'd0, tx_data}, 32'hC1);
        finish_handshake("drop", 3);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("drop_idle%0d_start", k), {31'd0, tx_start}, 32'd0);
            check($sformatf("drop_idle%0d_data", k), {24'd0, tx_data}, 32'hC1);
        end
        check("drop_final_grant", {30'd0, grant_id}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_uart_tx_arbiter
